mpu_result_streamer: RTL and testbench

//   Consumer side of the MPU's combinational matrix result. Snapshots a

---
 rtl/mpu_result_streamer.sv | 114 +++++++++++
 tb/tb_mpu_result_streamer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_result_streamer.sv
// Snapshots a SIZE x SIZE result matrix on start and streams it row-major, one element per beat.
// Latency: first element valid the cycle after start; backpressure holds the current beat until out_ready.
module mpu_result_streamer #(
    parameter int SIZE  = 5,
    parameter int WIDTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [SIZE*SIZE*WIDTH-1:0]  result_flat,
    input  logic                        start,
    output logic [WIDTH-1:0]            out_data,
    output logic [2:0]                  out_row,
    output logic [2:0]                  out_col,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam logic [2:0] LAST = 3'(SIZE - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                       state_q;
    logic [SIZE*SIZE*WIDTH-1:0]   snap_q;
    logic [WIDTH-1:0]             data_q;
    logic [2:0]                   row_q, col_q;
    logic                         last_q, valid_q, busy_q, done_q;

    logic                         beat, at_end, last_d;
    logic [2:0]                   row_d, col_d;
    logic [WIDTH-1:0]             data_d;
    int                           nidx;

    always_comb begin
        beat   = valid_q && out_ready;
        at_end = (row_q == LAST) && (col_q == LAST);
        row_d  = row_q;
        col_d  = col_q;
        if (col_q == LAST) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
        end else begin
            col_d = col_q + 3'd1;
        end
        // Keep the slice in range on the final beat; its data is never presented.
        nidx   = at_end ? 0 : (int'(row_d) * SIZE + int'(col_d));
        data_d = snap_q[nidx*WIDTH +: WIDTH];
        last_d = (row_d == LAST) && (col_d == LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            data_q  <= '0;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q  <= result_flat;
                        data_q  <= result_flat[WIDTH-1:0];
                        row_q   <= 3'd0;
                        col_q   <= 3'd0;
                        last_q  <= (LAST == 3'd0);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat) begin
                        if (at_end) begin
                            data_q  <= '0;
                            row_q   <= 3'd0;
                            col_q   <= 3'd0;
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            data_q <= data_d;
                            row_q  <= row_d;
                            col_q  <= col_d;
                            last_q <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mpu_result_streamer.sv
// Directed bench for mpu_result_streamer: reset, full rate, backpressure, isolation, mid-stream reset, back-to-back.
module tb_mpu_result_streamer;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [199:0] result_flat = '0;
    logic         start = 1'b0;
    logic [7:0]   out_data;
    logic [2:0]   out_row, out_col;
    logic         out_last, out_valid, out_ready = 1'b0, busy, done;

    int checks = 0;
    int failures = 0;

    mpu_result_streamer #(.SIZE(5), .WIDTH(8)) dut (
        .clock(clock), .reset(reset), .result_flat(result_flat), .start(start),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_matrix(input int base);
        for (int i = 0; i < 25; i++) result_flat[i*8 +: 8] = 8'(base + i);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_data, out_row, out_col, out_last, out_valid, busy, done} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs got data=%0d row=%0d col=%0d last=%b valid=%b busy=%b done=%b want all zero",
                     out_data, out_row, out_col, out_last, out_valid, busy, done);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_full_rate();
        set_matrix(0);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 8'(k) || out_row !== 3'(k/5) ||
                out_col !== 3'(k%5) || out_last !== (k == 24) || done !== 1'b0) begin
                failures++;
                $display("FAIL full_rate_beat%0d got v=%b b=%b data=%0d row=%0d col=%0d last=%b done=%b want data=%0d row=%0d col=%0d last=%b",
                         k, out_valid, busy, out_data, out_row, out_col, out_last, done, k, k/5, k%5, k == 24);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_rate_done got done=%b valid=%b busy=%b want 1 0 0", done, out_valid, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL full_rate_done_pulse got done=%b want 0", done);
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        int c = 0;
        set_matrix(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (k < 25 && c < 200) begin
            out_ready = (c % 3 == 0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(k) || out_row !== 3'(k/5) || out_col !== 3'(k%5) ||
                out_last !== (k == 24) || done !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_cycle%0d got v=%b data=%0d row=%0d col=%0d last=%b done=%b want data=%0d row=%0d col=%0d",
                         c, out_valid, out_data, out_row, out_col, out_last, done, k, k/5, k%5);
            end
            tick();
            if (out_ready) k++;
            c++;
        end
        out_ready = 1'b1;
        checks++;
        if (k != 25 || done !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_done got beats=%0d done=%b valid=%b want 25 1 0", k, done, out_valid);
        end
        tick();
    endtask

    task automatic test_isolation();
        set_matrix(0);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        result_flat = '1;
        for (int k = 0; k < 25; k++) begin
            start = (k == 10);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(k) || out_row !== 3'(k/5) || out_col !== 3'(k%5)) begin
                failures++;
                $display("FAIL isolation_beat%0d got v=%b data=%0d row=%0d col=%0d want data=%0d row=%0d col=%0d",
                         k, out_valid, out_data, out_row, out_col, k, k/5, k%5);
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL isolation_done got done=%b want 1", done);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL isolation_start_not_queued got valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        set_matrix(100);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (out_data !== 8'd107 || out_row !== 3'd1 || out_col !== 3'd2) begin
            failures++;
            $display("FAIL reset_mid_pre got data=%0d row=%0d col=%0d want 107 1 2", out_data, out_row, out_col);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_data, out_row, out_col, out_last, out_valid, busy, done} !== 18'd0) begin
            failures++;
            $display("FAIL reset_mid_async got data=%0d row=%0d col=%0d valid=%b busy=%b done=%b want all zero",
                     out_data, out_row, out_col, out_valid, busy, done);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_no_done cycle%0d got done=%b valid=%b want 0 0", c, done, out_valid);
            end
        end
        set_matrix(200);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(200 + k) || out_row !== 3'(k/5) || out_col !== 3'(k%5)) begin
                failures++;
                $display("FAIL reset_mid_restart_beat%0d got v=%b data=%0d row=%0d col=%0d want data=%0d row=%0d col=%0d",
                         k, out_valid, out_data, out_row, out_col, 200 + k, k/5, k%5);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_restart_done got done=%b want 1", done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        set_matrix(0);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        for (int k = 0; k < 25; k++) tick();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first_done got done=%b valid=%b want 1 0", done, out_valid);
        end
        set_matrix(50);
        tick();
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 8'(50 + k) || out_row !== 3'(k/5) ||
                out_col !== 3'(k%5) || out_last !== (k == 24)) begin
                failures++;
                $display("FAIL b2b_second_beat%0d got v=%b b=%b data=%0d row=%0d col=%0d last=%b want data=%0d row=%0d col=%0d",
                         k, out_valid, busy, out_data, out_row, out_col, out_last, 50 + k, k/5, k%5);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_done got done=%b busy=%b want 1 0", done, busy);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_isolation();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
